ycbcr422_unpack: RTL and testbench
==================================

# ycbcr422_unpack

Receive-side decoder for the 4:2:2 multiplexed YCbCr video stream used on the HDMI path. It accepts one 16-bit pixel word per clock, where even pixels carry {Y, Cb} and odd pixels carry {Y, Cr}. It rebuilds full 4:4:4 {Y, Cb, Cr} per pixel with sync and data-enable aligned to the data. It also tracks pixel/line position, measures the active resolution of each frame and flags malformed lines; it sits between the video input and any downstream capture or scaler logic.

## Interface
- vsync_active, 1'b1, level of i_vsync that marks the vertical sync pulse
- Reset i_nrst, asynchronous, active-low; clock i_clk.
- i_nrst  in  1  reset, asynchronous, active-low
- i_clk  in  1  pixel clock
- i_hsync  in  1  horizontal sync
- i_vsync  in  1  vertical sync
- i_de  in  1  data enable, active pixel when 1
- i_YCbCr  in  18  [15:8] Y, [7:0] Cb (even pixel) or Cr (odd pixel); [17:16] ignored
- o_hsync, o_vsync, o_de  out  1 each  inputs delayed 3 cycles
- o_Y, o_Cb, o_Cr  out  8 each  reconstructed 4:4:4 pixel
- o_x  out  11  column of the output pixel
- o_y  out  10  active-line index of the output pixel
- o_width  out  11  pixel count of the last completed active line
- o_height  out  10  active-line count of the last completed frame
- o_frame_done  out  1  one-cycle pulse when o_height updates
- o_locked  out  1  1 once a vsync leading edge has been seen after reset
- o_err_odd  out  1  sticky; an active line had an odd pixel count

## Operation
- Phase: 0 on the first de=1 cycle after a de=0 cycle; toggles every de=1 cycle. Phase 0 means the word carries Cb; phase 1 means it carries Cr.
- Pipeline: stage s1 and stage s2, each holding {Y, C, de, hs, vs, phase}, plus a held-Cb register.
- Output register, when s2 holds phase 0 with de=1: Y=s2.Y, Cb=s2.C. Cr=s1.C if s1.de=1 and s1.phase=1; otherwise Cr=8'd128 and o_err_odd is set.
- Output register, when s2 holds phase 1: Y=s2.Y, Cr=s2.C, Cb=held Cb from the preceding even pixel.
- Output register, when s2.de=0: o_Y, o_Cb, o_Cr = 0.
- x counter: 0 on the first output pixel of a line, +1 per output de cycle, saturates at 2047.
- On the output de falling edge: o_width <= pixel count of that line; y +1, saturating at 1023.
- Frame state machine, WAIT_VS -> FRAME:
  - WAIT_VS (reset state): counters run but o_height is not updated.
  - Leading edge of vsync (input side, changes to vsync_active) in WAIT_VS: go to FRAME, o_locked=1, y=0.
  - Each vsync leading edge in FRAME: o_height <= line count, o_frame_done=1 for one cycle, y=0.
- De gap of any length, including 1 cycle, ends the line. A de=1 run spanning a vsync edge is counted in the new frame.
- Sync and de pass through unchanged in value; polarity is applied only to vsync edge detection.

## Timing
- Latency: input cycle t appears on all o_* data/sync/de outputs at t+3, for every pixel of every line.
- o_x and o_y are aligned with o_Y.
- o_width updates on the cycle after the last o_de=1.
- o_frame_done asserts on the cycle after the vsync leading edge reaches the output stage, i.e. t+4 from the input edge.
- Reset values: all outputs 0, o_Cb and o_Cr included; FSM in WAIT_VS; phase 0.
- Reset mid-line: pipeline is flushed; the partial line produces no o_width update; o_err_odd is cleared.

## Structure
- Package ycbcr422_unpack_pkg holds:
  - the registers struct
  - the reset constant
  - the state enum {WAIT_VS, FRAME}
  - CHROMA_NEUTRAL = 8'd128
- Single always_comb plus always_ff with asynchronous reset; no sub-module.

## Test plan
- Even 4-pixel line, words {10,20},{11,30},{12,40},{13,50} -> three cycles later, outputs (10,20,30),(11,20,30),(12,40,50),(13,40,50); o_x 0..3; then o_width=4; o_err_odd=0.
- 3-pixel line {10,20},{11,30},{12,40} -> third output pixel (12,40,128); o_err_odd=1 and stays 1 across later good frames until reset.
- Two lines separated by a 1-cycle de gap, second line starting {50,60},{51,70} -> second line phase restarts; outputs (50,60,70),(51,60,70); o_x restarts at 0; o_y goes 0 -> 1.
- vsync pulse, then 4 lines of 1280 pixels, then vsync -> o_locked=1 after the first edge; at the second edge o_height=4, o_width=1280, and o_frame_done is a single-cycle pulse.
- vsync_active=0, with a low-going vsync pulse -> same results as the previous scenario.
- Reset asserted mid-line at pixel 700 -> all outputs 0 immediately. After release, o_locked stays 0 and o_height does not update until the first vsync leading edge.

Source files
------------

// File: rtl/ycbcr422_unpack_pkg.sv
// rtl/ycbcr422_unpack_pkg.sv - shared types, constants and helpers for ycbcr422_unpack
package ycbcr422_unpack_pkg;

  localparam logic [7:0] CHROMA_NEUTRAL = 8'd128;

  typedef enum logic {
    WAIT_VS = 1'b0,
    FRAME   = 1'b1
  } state_t;

  // one pipeline slot: luma, the chroma sample it carried, syncs and its phase
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] c;
    logic       de;
    logic       hs;
    logic       vs;
    logic       phase;
  } stage_t;

  typedef struct packed {
    state_t      state;
    stage_t      s1;
    stage_t      s2;
    logic [7:0]  hold_cb;
    logic [7:0]  pix_y;
    logic [7:0]  pix_cb;
    logic [7:0]  pix_cr;
    logic        de;
    logic        hs;
    logic        vs;
    logic        vs_d;
    logic [10:0] col;
    logic [9:0]  row;
    logic [10:0] width;
    logic [9:0]  height;
    logic        frame_done;
    logic        err_odd;
  } regs_t;

  localparam regs_t REGS_RESET = regs_t'('0);

  function automatic logic [10:0] inc_sat11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] inc_sat10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/ycbcr422_unpack_if.sv
// rtl/ycbcr422_unpack_if.sv - video in/out bundle for ycbcr422_unpack
interface ycbcr422_unpack_if;
  logic        i_hsync;
  logic        i_vsync;
  logic        i_de;
  logic [17:0] i_YCbCr;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [7:0]  o_Y;
  logic [7:0]  o_Cb;
  logic [7:0]  o_Cr;
  logic [10:0] o_x;
  logic [9:0]  o_y;
  logic [10:0] o_width;
  logic [9:0]  o_height;
  logic        o_frame_done;
  logic        o_locked;
  logic        o_err_odd;

  modport master (
    output i_hsync, i_vsync, i_de, i_YCbCr,
    input  o_hsync, o_vsync, o_de, o_Y, o_Cb, o_Cr, o_x, o_y,
           o_width, o_height, o_frame_done, o_locked, o_err_odd
  );

  modport slave (
    input  i_hsync, i_vsync, i_de, i_YCbCr,
    output o_hsync, o_vsync, o_de, o_Y, o_Cb, o_Cr, o_x, o_y,
           o_width, o_height, o_frame_done, o_locked, o_err_odd
  );
endinterface

// File: rtl/ycbcr422_unpack.sv
// rtl/ycbcr422_unpack.sv - 4:2:2 YCbCr to 4:4:4 unpacker with position and resolution tracking
module ycbcr422_unpack
  import ycbcr422_unpack_pkg::*;
#(
  parameter logic vsync_active = 1'b1
) (
  input logic              i_clk,
  input logic              i_nrst,
  ycbcr422_unpack_if.slave bus
);

  regs_t r;
  regs_t rin;
  logic  vs_edge;
  logic  line_end;
  logic  unused_hi;

  // bits [17:16] of the pixel word carry nothing for this format
  assign unused_hi = ^bus.i_YCbCr[17:16];

  // next-state: input capture, chroma pairing, position counters and frame FSM
  always_comb begin
    rin      = r;
    vs_edge  = 1'b0;
    line_end = 1'b0;

    // phase restarts at 0 on the first active word after any gap
    rin.s1.y     = bus.i_YCbCr[15:8];
    rin.s1.c     = bus.i_YCbCr[7:0];
    rin.s1.de    = bus.i_de;
    rin.s1.hs    = bus.i_hsync;
    rin.s1.vs    = bus.i_vsync;
    rin.s1.phase = bus.i_de & r.s1.de & ~r.s1.phase;
    rin.s2       = r.s1;

    rin.de         = r.s2.de;
    rin.hs         = r.s2.hs;
    rin.vs         = r.s2.vs;
    rin.vs_d       = r.vs;
    rin.frame_done = 1'b0;

    if (r.s2.de) begin
      rin.pix_y = r.s2.y;
      if (!r.s2.phase) begin
        // even pixel: Cr comes from the odd partner one stage behind
        rin.hold_cb = r.s2.c;
        rin.pix_cb  = r.s2.c;
        if (r.s1.de && r.s1.phase) begin
          rin.pix_cr = r.s1.c;
        end else begin
          rin.pix_cr  = CHROMA_NEUTRAL;
          rin.err_odd = 1'b1;
        end
      end else begin
        rin.pix_cb = r.hold_cb;
        rin.pix_cr = r.s2.c;
      end
      rin.col = r.de ? inc_sat11(r.col) : 11'd0;
    end else begin
      rin.pix_y  = 8'd0;
      rin.pix_cb = 8'd0;
      rin.pix_cr = 8'd0;
    end

    // output de falling edge closes the line
    line_end = r.de & ~r.s2.de;
    if (line_end) begin
      rin.width = inc_sat11(r.col);
      rin.row   = inc_sat10(r.row);
    end

    // vsync leading edge as seen at the output stage
    vs_edge = (r.vs == vsync_active) && (r.vs_d != vsync_active);
    if (vs_edge) begin
      // a line finishing on the edge cycle belongs to the new frame
      rin.row = line_end ? 10'd1 : 10'd0;
      if (r.state == WAIT_VS) begin
        rin.state = FRAME;
      end else begin
        rin.height     = r.row;
        rin.frame_done = 1'b1;
      end
    end
  end

  // state register with asynchronous flush
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= REGS_RESET;
    end else begin
      r <= rin;
    end
  end

  assign bus.o_hsync      = r.hs;
  assign bus.o_vsync      = r.vs;
  assign bus.o_de         = r.de;
  assign bus.o_Y          = r.pix_y;
  assign bus.o_Cb         = r.pix_cb;
  assign bus.o_Cr         = r.pix_cr;
  assign bus.o_x          = r.col;
  assign bus.o_y          = r.row;
  assign bus.o_width      = r.width;
  assign bus.o_height     = r.height;
  assign bus.o_frame_done = r.frame_done;
  assign bus.o_locked     = (r.state == FRAME);
  assign bus.o_err_odd    = r.err_odd;

endmodule

// File: tb/tb_ycbcr422_unpack.sv
// tb/tb_ycbcr422_unpack.sv - directed self-checking bench for ycbcr422_unpack
module tb_ycbcr422_unpack;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ycbcr422_unpack_if vif_a ();
  ycbcr422_unpack_if vif_b ();

  ycbcr422_unpack #(.vsync_active(1'b1)) dut_a (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (vif_a.slave)
  );

  ycbcr422_unpack #(.vsync_active(1'b0)) dut_b (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (vif_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    chk({tag, ".de"}, 32'(vif_a.o_de), 32'd1);
    chk({tag, ".Y"},  32'(vif_a.o_Y),  32'(y));
    chk({tag, ".Cb"}, 32'(vif_a.o_Cb), 32'(cb));
    chk({tag, ".Cr"}, 32'(vif_a.o_Cr), 32'(cr));
  endtask

  // dut_b sees the same stream with vsync inverted
  task automatic drive(input logic de, input logic hs, input logic vs, input logic [7:0] y, input logic [7:0] c);
    vif_a.i_de    = de;
    vif_a.i_hsync = hs;
    vif_a.i_vsync = vs;
    vif_a.i_YCbCr = {2'b11, y, c};
    vif_b.i_de    = de;
    vif_b.i_hsync = hs;
    vif_b.i_vsync = ~vs;
    vif_b.i_YCbCr = {2'b11, y, c};
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [7:0] y, input logic [7:0] c);
    drive(1'b1, 1'b0, 1'b0, y, c);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic vs_cyc();
    drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    vif_a.i_de = 1'b0; vif_a.i_hsync = 1'b0; vif_a.i_vsync = 1'b0; vif_a.i_YCbCr = '0;
    vif_b.i_de = 1'b0; vif_b.i_hsync = 1'b0; vif_b.i_vsync = 1'b1; vif_b.i_YCbCr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.de",     32'(vif_a.o_de),       32'd0);
    chk("rst.Y",      32'(vif_a.o_Y),        32'd0);
    chk("rst.Cb",     32'(vif_a.o_Cb),       32'd0);
    chk("rst.Cr",     32'(vif_a.o_Cr),       32'd0);
    chk("rst.x",      32'(vif_a.o_x),        32'd0);
    chk("rst.width",  32'(vif_a.o_width),    32'd0);
    chk("rst.locked", 32'(vif_a.o_locked),   32'd0);
    chk("rst.err",    32'(vif_a.o_err_odd),  32'd0);
    nrst = 1'b1;
    idle(4);

    // two even lines split by a single-cycle de gap
    px(8'd10, 8'd20); px(8'd11, 8'd30); px(8'd12, 8'd40);
    chk_pix("a0", 8'd10, 8'd20, 8'd30);
    chk("a0.x", 32'(vif_a.o_x), 32'd0);
    chk("a0.y", 32'(vif_a.o_y), 32'd0);
    px(8'd13, 8'd50);
    chk_pix("a1", 8'd11, 8'd20, 8'd30);
    chk("a1.x", 32'(vif_a.o_x), 32'd1);
    idle(1);
    chk_pix("a2", 8'd12, 8'd40, 8'd50);
    chk("a2.x", 32'(vif_a.o_x), 32'd2);
    px(8'd50, 8'd60);
    chk_pix("a3", 8'd13, 8'd40, 8'd50);
    chk("a3.x", 32'(vif_a.o_x), 32'd3);
    px(8'd51, 8'd70);
    chk("gap.de",    32'(vif_a.o_de),    32'd0);
    chk("gap.Y",     32'(vif_a.o_Y),     32'd0);
    chk("gap.width", 32'(vif_a.o_width), 32'd4);
    px(8'd52, 8'd80);
    chk_pix("b0", 8'd50, 8'd60, 8'd70);
    chk("b0.x", 32'(vif_a.o_x), 32'd0);
    chk("b0.y", 32'(vif_a.o_y), 32'd1);
    px(8'd53, 8'd90);
    chk_pix("b1", 8'd51, 8'd60, 8'd70);
    chk("b1.x", 32'(vif_a.o_x), 32'd1);
    idle(1);
    chk_pix("b2", 8'd52, 8'd80, 8'd90);
    idle(1);
    chk_pix("b3", 8'd53, 8'd80, 8'd90);
    idle(1);
    chk("b.width", 32'(vif_a.o_width),   32'd4);
    chk("b.err",   32'(vif_a.o_err_odd), 32'd0);
    chk("b.y",     32'(vif_a.o_y),       32'd2);

    // hsync passes through three cycles late
    drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1);
    chk("hs.t2", 32'(vif_a.o_hsync), 32'd0);
    idle(1);
    chk("hs.t3", 32'(vif_a.o_hsync), 32'd1);
    idle(1);
    chk("hs.t4", 32'(vif_a.o_hsync), 32'd0);

    // odd-length line
    px(8'd10, 8'd20); px(8'd11, 8'd30); px(8'd12, 8'd40);
    chk_pix("c0", 8'd10, 8'd20, 8'd30);
    idle(1);
    chk_pix("c1", 8'd11, 8'd20, 8'd30);
    idle(1);
    chk_pix("c2", 8'd12, 8'd40, 8'd128);
    chk("c2.err", 32'(vif_a.o_err_odd), 32'd1);
    idle(1);
    chk("c.width", 32'(vif_a.o_width), 32'd3);
    idle(4);

    // first vsync edge locks without touching height
    chk("lk.pre_a", 32'(vif_a.o_locked), 32'd0);
    chk("lk.pre_b", 32'(vif_b.o_locked), 32'd0);
    vs_cyc(); vs_cyc();
    chk("lk.k1", 32'(vif_a.o_locked), 32'd0);
    vs_cyc();
    chk("lk.k2",  32'(vif_a.o_locked), 32'd0);
    chk("lk.row", 32'(vif_a.o_y),      32'd3);
    idle(1);
    chk("lk.a",    32'(vif_a.o_locked),     32'd1);
    chk("lk.b",    32'(vif_b.o_locked),     32'd1);
    chk("lk.fd",   32'(vif_a.o_frame_done), 32'd0);
    chk("lk.h",    32'(vif_a.o_height),     32'd0);
    chk("lk.y0",   32'(vif_a.o_y),          32'd0);
    idle(10);

    // four lines of 1280
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 1280; i++) px(8'(i), 8'(i * 3));
      idle(20);
    end
    chk("fr.width_a", 32'(vif_a.o_width), 32'd1280);
    chk("fr.width_b", 32'(vif_b.o_width), 32'd1280);
    vs_cyc(); vs_cyc(); vs_cyc();
    chk("fr.fd_k2", 32'(vif_a.o_frame_done), 32'd0);
    idle(1);
    chk("fr.fd_a", 32'(vif_a.o_frame_done), 32'd1);
    chk("fr.fd_b", 32'(vif_b.o_frame_done), 32'd1);
    chk("fr.h_a",  32'(vif_a.o_height),     32'd4);
    chk("fr.h_b",  32'(vif_b.o_height),     32'd4);
    idle(1);
    chk("fr.fd_k4a", 32'(vif_a.o_frame_done), 32'd0);
    chk("fr.fd_k4b", 32'(vif_b.o_frame_done), 32'd0);
    chk("fr.err",    32'(vif_a.o_err_odd),    32'd1);
    idle(5);

    // reset in the middle of a line
    for (int i = 0; i < 700; i++) px(8'(i), 8'(i));
    nrst = 1'b0;
    #1;
    chk("mr.de",     32'(vif_a.o_de),      32'd0);
    chk("mr.Y",      32'(vif_a.o_Y),       32'd0);
    chk("mr.x",      32'(vif_a.o_x),       32'd0);
    chk("mr.width",  32'(vif_a.o_width),   32'd0);
    chk("mr.height", 32'(vif_a.o_height),  32'd0);
    chk("mr.locked", 32'(vif_a.o_locked),  32'd0);
    chk("mr.err",    32'(vif_a.o_err_odd), 32'd0);
    idle(3);
    @(negedge clk);
    nrst = 1'b1;
    idle(10);
    chk("mr.width_post", 32'(vif_a.o_width),  32'd0);
    px(8'd1, 8'd2); px(8'd3, 8'd4); px(8'd5, 8'd6); px(8'd7, 8'd8);
    idle(8);
    chk("mr.width_new", 32'(vif_a.o_width),  32'd4);
    chk("mr.lk_new",    32'(vif_a.o_locked), 32'd0);
    chk("mr.h_new",     32'(vif_a.o_height), 32'd0);
    vs_cyc(); vs_cyc(); vs_cyc();
    idle(1);
    chk("mr.lk_vs", 32'(vif_a.o_locked),     32'd1);
    chk("mr.fd_vs", 32'(vif_a.o_frame_done), 32'd0);
    chk("mr.h_vs",  32'(vif_a.o_height),     32'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
